// File: rtl/xor_mac_sequencer.sv
// Time-multiplexed 2-2-1 XOR network: one shared MAC walks every hidden and output term
// using a writable weight file, with valid/ready handshakes on input and prediction.
module xor_mac_sequencer #(
    parameter int unsigned BITS_PER_WORD = 8,
    parameter int unsigned INPUT_SIZE    = 2,
    parameter int unsigned HIDDEN_SIZE   = 2,
    parameter int unsigned ACC_BITS      = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            w_wr_en,
    input  logic [3:0]                      w_addr,
    input  logic signed [BITS_PER_WORD-1:0] w_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INPUT_SIZE-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [BITS_PER_WORD-1:0] out_data,
    output logic                            busy
);

    localparam int unsigned AW        = 4;
    localparam int unsigned NUM_SLOTS = 2 ** AW;
    localparam int unsigned XW        = INPUT_SIZE + 1;
    localparam int unsigned OUT_BASE  = HIDDEN_SIZE * XW;
    localparam int unsigned NUM_W     = OUT_BASE + HIDDEN_SIZE + 1;
    localparam int unsigned IW        = $clog2(INPUT_SIZE + 1);
    localparam int unsigned JW        = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
    localparam int unsigned KW        = $clog2(HIDDEN_SIZE + 1);

    typedef logic signed [BITS_PER_WORD-1:0] word_t;
    typedef logic signed [ACC_BITS-1:0]      acc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIDDEN,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam acc_t WORD_MAX = acc_t'((2 ** (BITS_PER_WORD - 1)) - 1);
    localparam acc_t WORD_MIN = -WORD_MAX - acc_t'(1);

    // Power-on weights solve XOR; slots past the last weight are never written.
    localparam word_t W_RESET [NUM_SLOTS] = '{
        0: word_t'(0),  1: word_t'(1), 2: word_t'(1),
        3: word_t'(-1), 4: word_t'(1), 5: word_t'(1),
        6: word_t'(0),  7: word_t'(1), 8: word_t'(-2),
        default: word_t'(0)
    };

    function automatic word_t relu_sat(input acc_t v);
        if (v < acc_t'(0))    return word_t'(0);
        else if (v > WORD_MAX) return word_t'(WORD_MAX);
        else                   return word_t'(v);
    endfunction

    function automatic word_t sat(input acc_t v);
        if (v < WORD_MIN)      return word_t'(WORD_MIN);
        else if (v > WORD_MAX) return word_t'(WORD_MAX);
        else                   return word_t'(v);
    endfunction

    state_t          state_q, state_d;
    acc_t            acc_q, acc_d;
    logic [IW-1:0]   i_q, i_d;
    logic [JW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic [XW-1:0]   x_q, x_d;
    word_t           h_q [HIDDEN_SIZE];
    word_t           h_d [HIDDEN_SIZE];
    word_t           w_q [NUM_SLOTS];
    word_t           w_d [NUM_SLOTS];
    logic            out_valid_q, out_valid_d;
    word_t           out_data_q, out_data_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]   hid_addr_c, out_addr_c;
    acc_t            hid_term_c, out_term_c, hid_sum_c, out_sum_c;
    word_t           h_k_c;

    // Operand selection for the shared MAC; h[0] is the constant bias activation.
    always_comb begin
        hid_addr_c = AW'(j_q) * AW'(XW) + AW'(i_q);
        out_addr_c = AW'(OUT_BASE) + AW'(k_q);
        hid_term_c = x_q[i_q] ? acc_t'(w_q[hid_addr_c]) : '0;
        h_k_c      = (k_q == '0) ? word_t'(1) : h_q[JW'(k_q - KW'(1))];
        out_term_c = acc_t'(h_k_c) * acc_t'(w_q[out_addr_c]);
        hid_sum_c  = acc_q + hid_term_c;
        out_sum_c  = acc_q + out_term_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            x_q         <= '0;
            h_q         <= '{default: '0};
            w_q         <= W_RESET;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            x_q         <= x_d;
            h_q         <= h_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        x_d         = x_q;
        h_d         = h_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            S_IDLE: begin
                // Weight writes only land while idle, including on the accept cycle.
                if (w_wr_en && (w_addr < AW'(NUM_W))) begin
                    w_d[w_addr] = w_data;
                end
                if (in_valid) begin
                    x_d     = {in_data, 1'b1};
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_HIDDEN;
                end
            end
            S_HIDDEN: begin
                if (i_q == IW'(INPUT_SIZE)) begin
                    h_d[j_q] = relu_sat(hid_sum_c);
                    acc_d    = '0;
                    i_d      = '0;
                    if (j_q == JW'(HIDDEN_SIZE - 1)) begin
                        j_d     = '0;
                        k_d     = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end else begin
                    acc_d = hid_sum_c;
                    i_d   = i_q + IW'(1);
                end
            end
            S_OUTPUT: begin
                if (k_q == KW'(HIDDEN_SIZE)) begin
                    out_data_d  = sat(out_sum_c);
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    k_d         = '0;
                    state_d     = S_DONE;
                end else begin
                    acc_d = out_sum_c;
                    k_d   = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xor_mac_sequencer.sv
// Scoreboard bench for xor_mac_sequencer: directed scenarios plus random traffic
// checked against an arithmetic model of the XOR network.
module tb_xor_mac_sequencer;

    localparam int USE_MODEL = 1000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              w_wr_en = 1'b0;
    logic [3:0]        w_addr = '0;
    logic signed [7:0] w_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_data;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cnt = 0;
    int exp_q[$];
    int lat_q[$];
    int acc_cycles[$];
    int wm[9];
    bit prev_v = 1'b0;
    int held = 0;
    int tgt = 0;

    xor_mac_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .w_wr_en   (w_wr_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        wm = '{0, 1, 1, -1, 1, 1, 0, 1, -2};
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Network evaluated directly from the weight table with integer arithmetic.
    function automatic int predict(input logic [1:0] x);
        int xb[3];
        int h[3];
        int s;
        xb[0] = 1;
        xb[1] = int'(x[0]);
        xb[2] = int'(x[1]);
        h[0] = 1;
        for (int j = 0; j < 2; j++) begin
            s = 0;
            for (int i = 0; i < 3; i++) s += xb[i] * wm[j * 3 + i];
            h[j + 1] = clamp(s, 0, 127);
        end
        s = 0;
        for (int k = 0; k < 3; k++) s += h[k] * wm[6 + k];
        return clamp(s, -128, 127);
    endfunction

    // Monitor: latency on each new prediction, stability under backpressure, data on handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_v) begin
                    if (lat_q.size() == 0) chk("unexpected_output", 1, 0);
                    else chk("latency", cyc - lat_q.pop_front(), 9);
                    held = int'(out_data);
                end else begin
                    chk("hold_data", int'(out_data), held);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) chk("result_no_expect", int'(out_data), -999);
                    else chk("result", int'(out_data), exp_q.pop_front());
                    hs_cnt++;
                end
            end
            prev_v = out_valid && !out_ready;
        end
    end

    task automatic send(input logic [1:0] x, input int expv, input bit wr,
                        input logic [3:0] a, input logic signed [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = x;
        w_wr_en  = wr;
        w_addr   = a;
        w_data   = d;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            w_wr_en  = 1'b0;
            return;
        end
        if (wr && a < 4'd9) wm[int'(a)] = int'(d);
        exp_q.push_back((expv == USE_MODEL) ? predict(x) : expv);
        lat_q.push_back(cyc + 1);
        acc_cycles.push_back(cyc + 1);
        tgt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_wr_en  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic signed [7:0] d, input bit land);
        @(posedge clk); #1;
        w_wr_en = 1'b1;
        w_addr  = a;
        w_data  = d;
        @(posedge clk); #1;
        w_wr_en = 1'b0;
        if (land && a < 4'd9) wm[int'(a)] = int'(d);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (hs_cnt < target) chk("handshake_timeout", hs_cnt, target);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int hold;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("inreset_out_valid", int'(out_valid), 0);
        chk("inreset_busy", int'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Truth table back to back at full rate.
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2'b00, 0, 1'b0, '0, '0);
        send(2'b01, 1, 1'b0, '0, '0);
        send(2'b10, 1, 1'b0, '0, '0);
        send(2'b11, 0, 1'b0, '0, '0);
        wait_hs(tgt);
        for (int p = 1; p < 4; p++) chk("period", acc_cycles[p] - acc_cycles[p - 1], 11);

        // Backpressure with a competing input request.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(2'b01, 1, 1'b0, '0, '0);
        wait_valid();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 2'b11;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'(out_data), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_busy", int'(busy), 0);
        wait_hs(tgt);

        // Weight writes: landing, out of range, dropped while busy, same-cycle with accept.
        wr(4'd8, -8'sd1, 1'b1);
        send(2'b11, 1, 1'b0, '0, '0);
        wait_hs(tgt);
        wr(4'd9, 8'sd5, 1'b0);
        send(2'b11, 1, 1'b0, '0, '0);
        wr(4'd6, 8'sd50, 1'b0);
        wait_hs(tgt);
        send(2'b11, 1, 1'b0, '0, '0);
        wait_hs(tgt);
        send(2'b11, 0, 1'b1, 4'd8, -8'sd2);
        wait_hs(tgt);

        // Saturation of hidden and output values.
        wr(4'd0, 8'sd127, 1'b1);
        wr(4'd1, 8'sd127, 1'b1);
        wr(4'd2, 8'sd127, 1'b1);
        wr(4'd7, 8'sd127, 1'b1);
        wr(4'd8, 8'sd0, 1'b1);
        send(2'b11, 127, 1'b0, '0, '0);
        wait_hs(tgt);
        wr(4'd6, -8'sd128, 1'b1);
        wr(4'd7, 8'sd0, 1'b1);
        send(2'b11, -128, 1'b0, '0, '0);
        wait_hs(tgt);

        // Reset in the middle of a computation restores default weights.
        send(2'b01, USE_MODEL, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        exp_q.delete();
        lat_q.delete();
        tgt--;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        send(2'b01, 1, 1'b0, '0, '0);
        wait_hs(tgt);

        // Random weights, inputs and backpressure.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0)
                wr(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
            hold = int'($urandom_range(0, 4));
            @(posedge clk); #1;
            out_ready = (hold == 0);
            send(2'($urandom_range(0, 3)), USE_MODEL, 1'b0, '0, '0);
            wait_valid();
            if (hold > 0) begin
                repeat (hold) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            wait_hs(tgt);
        end

        repeat (3) @(posedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
